// File: rtl/imem_fetch_responder_pkg.sv
// core_pkg: shared types for the instruction fetch responder and its queues
package core_pkg;
    localparam int CORE_XLEN = 32;
    typedef struct packed {
        logic [CORE_XLEN-1:0] addr;
        logic [CORE_XLEN-1:0] instr;
    } fetch_entry_t;
    typedef enum logic {RUN, DRAIN} fsm_state_t;
endpackage

// File: rtl/imem_fetch_responder_if.sv
// imem_fetch_responder_if: fetch-stage channel, redirect and instruction memory bus
interface imem_fetch_responder_if #(parameter int XLEN = 32) ();
    logic            fetch_en_i;
    logic            flush_i;
    logic [XLEN-1:0] flush_addr_i;
    logic            out_ready_i;
    logic [XLEN-1:0] out_addr_o;
    logic [XLEN-1:0] out_instr_o;
    logic            out_nstall_o;
    logic            mem_req_o;
    logic [XLEN-1:0] mem_addr_o;
    logic            mem_gnt_i;
    logic            mem_rvalid_i;
    logic [XLEN-1:0] mem_rdata_i;
    modport master (
        input  fetch_en_i, flush_i, flush_addr_i, out_ready_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output out_addr_o, out_instr_o, out_nstall_o, mem_req_o, mem_addr_o
    );
    modport slave (
        output fetch_en_i, flush_i, flush_addr_i, out_ready_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  out_addr_o, out_instr_o, out_nstall_o, mem_req_o, mem_addr_o
    );
endinterface

// File: rtl/imem_fetch_responder_fifo.sv
// fetch_fifo: circular buffer with push/pop/clear and occupancy count; head read combinationally
module fetch_fifo import core_pkg::*; #(
    parameter int WIDTH = 2 * CORE_XLEN,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic [CW-1:0]    o_count
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr, r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_pop;
    assign w_pop   = i_pop & (r_count != '0);
    assign o_data  = r_mem[r_rptr];
    assign o_count = r_count;
    // Clear takes priority over any push or pop in the same cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + CW'(i_push) - CW'(w_pop);
        end
    end
endmodule

// File: rtl/imem_fetch_responder.sv
// imem_fetch_responder: sequential instruction fetch with credit-limited requests and flush/discard
module imem_fetch_responder import core_pkg::*; #(
    parameter int              XLEN     = CORE_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = 32'h1000_0000,
    parameter int              DEPTH    = 4
) (
    input logic                    clk_i,
    input logic                    rst_ni,
    imem_fetch_responder_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = CW + 1;
    fsm_state_t      r_state, w_state_n;
    logic [CW-1:0]   r_discard, w_discard_n, w_inflight, w_occupancy;
    logic [XLEN-1:0] r_fetch_addr, w_head_addr;
    logic            w_grant, w_rvalid, w_resp_push, w_resp_pop;
    fetch_entry_t    w_push_entry, w_head;
    assign w_grant      = bus.mem_req_o & bus.mem_gnt_i;
    assign w_rvalid     = bus.mem_rvalid_i & (w_inflight != '0);
    assign w_resp_push  = w_rvalid & (r_state == RUN) & ~bus.flush_i;
    assign w_resp_pop   = bus.out_nstall_o & bus.out_ready_i;
    assign w_push_entry = '{addr: w_head_addr, instr: bus.mem_rdata_i};
    // Credits cover both words still in memory and words waiting in the queue
    assign bus.mem_req_o    = bus.fetch_en_i & ~bus.flush_i & ({1'b0, w_inflight} + {1'b0, w_occupancy} < SW'(DEPTH));
    assign bus.mem_addr_o   = r_fetch_addr;
    assign bus.out_nstall_o = w_occupancy != '0;
    assign bus.out_addr_o   = w_head.addr;
    assign bus.out_instr_o  = w_head.instr;
    always_comb begin
        w_discard_n = r_discard;
        if (bus.flush_i) w_discard_n = w_inflight + CW'(w_grant) - CW'(w_rvalid);
        else if (r_state == DRAIN && w_rvalid) w_discard_n = r_discard - 1'b1;
        w_state_n = (w_discard_n != '0) ? DRAIN : RUN;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= RUN;
            r_discard <= '0;
        end else begin
            r_state   <= w_state_n;
            r_discard <= w_discard_n;
        end
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_fetch_addr <= RESET_PC;
        else r_fetch_addr <= bus.flush_i ? {bus.flush_addr_i[XLEN-1:2], 2'b00} : w_grant ? r_fetch_addr + XLEN'(4) : r_fetch_addr;
    end
    fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_addr_fifo (
        .clk_i, .rst_ni,
        .i_push(w_grant), .i_pop(w_rvalid), .i_clear(1'b0),
        .i_data(r_fetch_addr), .o_data(w_head_addr), .o_count(w_inflight)
    );
    fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_resp_fifo (
        .clk_i, .rst_ni,
        .i_push(w_resp_push), .i_pop(w_resp_pop), .i_clear(bus.flush_i),
        .i_data(w_push_entry), .o_data(w_head), .o_count(w_occupancy)
    );
endmodule

// File: tb/tb_imem_fetch_responder.sv
// tb_imem_fetch_responder: directed and random stimulus against a queue-based fetch/memory model
module tb_imem_fetch_responder;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h1000_0000;
    logic        clk = 0;
    logic        rst_n = 0;
    int          n_vec = 0, n_err = 0, n_grant = 0;
    logic [31:0] m_fa = RESET_PC;
    logic [31:0] infl_addr[$];
    bit          infl_stale[$];
    logic [31:0] rq[$];
    logic [31:0] first_addr = 0;
    bit          got_first = 0;

    always #5 clk = ~clk;

    imem_fetch_responder_if #(.XLEN(32)) bus ();
    imem_fetch_responder #(.XLEN(32), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus.master)
    );

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        bus.fetch_en_i = 1; bus.flush_i = 0; bus.flush_addr_i = 0; bus.out_ready_i = 0;
        bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; bus.mem_rdata_i = 0;
        infl_addr.delete(); infl_stale.delete(); rq.delete();
        m_fa = RESET_PC;
        #1;
        chk("rst_req", bus.mem_req_o, 1);
        chk("rst_addr", bus.mem_addr_o, RESET_PC);
        chk("rst_nstall", bus.out_nstall_o, 0);
        chk("rst_out_addr", bus.out_addr_o, 0);
        chk("rst_out_instr", bus.out_instr_o, 0);
        @(posedge clk);
        #2 rst_n = 1;
    endtask

    task automatic step(bit en, bit fl, logic [31:0] fa, bit rdy, bit gnt, bit rv);
        bit req, grant, rv_eff, pop, s;
        logic [31:0] a;
        @(negedge clk);
        rv_eff = rv && infl_addr.size() > 0;
        req    = en && !fl && (infl_addr.size() + rq.size() < DEPTH);
        grant  = req && gnt;
        pop    = rq.size() > 0 && rdy && !fl;
        bus.fetch_en_i = en; bus.flush_i = fl; bus.flush_addr_i = fa; bus.out_ready_i = rdy;
        bus.mem_gnt_i = gnt; bus.mem_rvalid_i = rv;
        bus.mem_rdata_i = rv_eff ? mem_word(infl_addr[0]) : $urandom;
        #1;
        chk("mem_req", bus.mem_req_o, req);
        chk("mem_addr", bus.mem_addr_o, m_fa);
        chk("nstall", bus.out_nstall_o, rq.size() > 0);
        if (rq.size() > 0) begin
            chk("out_addr", bus.out_addr_o, rq[0]);
            chk("out_instr", bus.out_instr_o, mem_word(rq[0]));
        end
        if (bus.mem_req_o && gnt) n_grant++;
        if (pop && !got_first) begin
            got_first  = 1;
            first_addr = bus.out_addr_o;
        end
        if (pop) void'(rq.pop_front());
        if (rv_eff) begin
            a = infl_addr.pop_front();
            s = infl_stale.pop_front();
            if (!s && !fl) rq.push_back(a);
        end
        if (fl) begin
            rq.delete();
            foreach (infl_stale[i]) infl_stale[i] = 1;
            m_fa = {fa[31:2], 2'b00};
        end
        if (grant) begin
            infl_addr.push_back(m_fa);
            infl_stale.push_back(0);
            m_fa += 4;
        end
    endtask

    initial begin
        do_reset();
        for (int i = 0; i < 20; i++) step(1, 0, 0, 1, 1, 1);
        chk("stream_first", first_addr, 32'h1000_0000);

        do_reset();
        n_grant = 0;
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 1, 1);
        chk("full_grants", n_grant, 4);
        chk("full_req_low", bus.mem_req_o, 0);
        got_first = 0;
        step(1, 0, 0, 1, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        chk("resume_req", bus.mem_req_o, 1);
        chk("resume_addr", bus.mem_addr_o, 32'h1000_0010);
        for (int i = 0; i < 12; i++) step(1, 0, 0, 1, 1, 1);
        chk("full_first", first_addr, 32'h1000_0000);

        do_reset();
        step(1, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1, 0);
        step(1, 1, 32'h2000_0006, 0, 0, 0);
        step(1, 0, 0, 1, 0, 1);
        step(1, 0, 0, 1, 0, 1);
        chk("flush_nstall", bus.out_nstall_o, 0);
        got_first = 0;
        for (int i = 0; i < 6; i++) step(1, 0, 0, 1, 1, 1);
        chk("flush_first", first_addr, 32'h2000_0004);

        do_reset();
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, 0);
        step(1, 1, 32'h3000_0000, 1, 1, 1);
        got_first = 0;
        for (int i = 0; i < 10; i++) step(1, 0, 0, 1, 1, 1);
        chk("gnt_rv_flush_first", first_addr, 32'h3000_0000);

        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0, 0);
        chk("hold_addr", bus.mem_addr_o, m_fa);
        step(1, 0, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0, 1);

        step(1, 1, 32'hFFFF_FFFE, 1, 0, 0);
        step(1, 0, 0, 1, 1, 0);
        step(1, 0, 0, 1, 0, 1);
        chk("wrap_addr", bus.mem_addr_o, 32'h0000_0000);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 1, 1, 1);

        for (int i = 0; i < 3000; i++) begin
            if (i % 1000 == 500) do_reset();
            step($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0, $urandom,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
